dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the memory end of the core's load/store interface.
//  Accepts one request at a time, decodes the size/sign field with the shared funct3 codes,
//  applies byte-lane writes, and returns sign- or zero-extended load data.
//  Configurable wait states model slow memory; sits between the core's MEM stage and its word-wide RAM.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1
//  WAIT_CYCLES  1     extra cycles between accept and response, range 0..15
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept; high only in IDLE and while rst is low
//  req_we      in   1   1 = store, 0 = load
//  req_funct3  in   3   F3_BYTE/F3_HALF/F3_WORD; loads also F3_BU/F3_HU
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-aligned; only low 8/16 bits used for sb/sh
//  rsp_valid   out  1   response present; held until accepted
//  rsp_ready   in   1   requester accepts response
//  rsp_rdata   out  32  load result, extended; 0 for stores and errors
//  rsp_err     out  1   misaligned, out-of-range or illegal funct3
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//   latched request cleared; req_ready held 0 while rst=1. RAM contents are not reset.
//  FSM states: IDLE, WAIT, RESP.
//   IDLE: req_ready=1. On req_valid&&req_ready, latch we/funct3/addr/wdata.
//    WAIT_CYCLES=0 -> perform access, go RESP. Otherwise load counter with WAIT_CYCLES, go WAIT.
//   WAIT: decrement counter each cycle; when counter reaches 1, perform access, go RESP.
//   RESP: rsp_valid=1 with stable rsp_rdata/rsp_err; on rsp_ready, rsp_valid=0, go IDLE.
//  Latency: request accepted in cycle T -> rsp_valid first high in cycle T+1+WAIT_CYCLES.
//  Throughput: at most one request per (WAIT_CYCLES+2) cycles. No request is accepted in WAIT or RESP.
//  Access is performed exactly once per accepted request, on the edge that enters RESP.
//  Error checks, performed at access; on error: no RAM write, rsp_rdata=0, rsp_err=1.
//   - word index addr[31:2] >= DEPTH_WORDS
//   - F3_HALF/F3_HU with addr[0]=1
//   - F3_WORD with addr[1:0]!=0
//   - load funct3 other than 000,001,010,100,101
//   - store funct3 other than 000,001,010
//  Store: byte -> lane addr[1:0] gets wdata[7:0]; half -> lanes {addr[1],0} and {addr[1],1} get wdata[15:0];
//   word -> all 4 lanes. Untouched lanes keep prior value. Store response: rdata=0, err=0.
//  Load: lane select by addr[1:0]; F3_BYTE/F3_HALF sign-extend, F3_BU/F3_HU zero-extend, F3_WORD unmodified.
//  Byte order little-endian: lane 0 = bits [7:0].
//  Request inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.
//  rsp_rdata/rsp_err hold their last value after the response handshake; they are valid only with rsp_valid.
//  Reset mid-operation: pending request dropped. In WAIT, no write occurs.
//   In RESP, the write already happened and is retained. No response is issued after reset.
// TESTING
//  1. WAIT_CYCLES=1: sw 0xDEADBEEF @0x10 accepted cycle T -> rsp_valid at T+2, err=0;
//     lw @0x10 -> rdata=0xDEADBEEF.
//  2. After test 1: sb 0x80 @0x11 then lb @0x11 -> 0xFFFFFF80; lbu @0x11 -> 0x00000080;
//     lw @0x10 -> 0xDEAD80EF.
//  3. sh 0x1234 @0x22, lh @0x22 -> 0x00001234; sh 0xF00D @0x22, lh -> 0xFFFFF00D, lhu -> 0x0000F00D.
//  4. Errors: lw @0x13, lh @0x21, load funct3=3'b011, sw @(4*DEPTH_WORDS) -> each err=1, rdata=0;
//     memory at 0x10 unchanged.
//  5. Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0 throughout;
//     new req_valid is not accepted until handshake completes.
//  6. Reset: assert rst during WAIT of sw 0x55 @0x30 -> outputs 0 immediately, no response issued,
//     lw @0x30 after reset returns the prior value. Repeat with WAIT_CYCLES=0: back-to-back requests
//     produce rsp_valid in the cycle after accept.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: memory end of the core load/store port. One request in flight,
// optional wait states, byte-lane stores and sign/zero-extended loads.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_HALF = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  req_t req_q, req_nxt, cur;
  logic access;

  logic [3:0][7:0] mem [DEPTH_WORDS];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_nxt   = req_q;
    access    = 1'b0;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && req_ready) begin
          req_nxt = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
          if (WAIT_CYCLES == 0) begin
            access    = 1'b1;
            state_nxt = RESP;
          end else begin
            cnt_nxt   = WAIT_INIT;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          access    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so decode the live request.
  assign cur = (state == IDLE) ? req_nxt : req_q;

  logic [1:0]       lane;
  logic [IDX_W-1:0] idx;
  logic             in_range, misal, bad_f3, err;

  assign lane     = cur.addr[1:0];
  assign idx      = cur.addr[IDX_W+1:2];
  assign in_range = cur.addr[31:2] < 30'(DEPTH_WORDS);

  always_comb begin
    bad_f3 = 1'b1;
    misal  = 1'b0;
    case (cur.funct3)
      F3_BYTE: bad_f3 = 1'b0;
      F3_HALF: begin bad_f3 = 1'b0;   misal = lane[0]; end
      F3_WORD: begin bad_f3 = 1'b0;   misal = |lane;   end
      F3_BU:   bad_f3 = cur.we;
      F3_HU:   begin bad_f3 = cur.we; misal = lane[0]; end
      default: bad_f3 = 1'b1;
    endcase
  end

  assign err = bad_f3 | misal | !in_range;

  logic [31:0] rd_word, sh_word, ld_data;
  assign rd_word = mem[idx];
  assign sh_word = rd_word >> {lane, 3'b000};

  always_comb begin
    case (cur.funct3)
      F3_BYTE: ld_data = {{24{sh_word[7]}}, sh_word[7:0]};
      F3_HALF: ld_data = {{16{sh_word[15]}}, sh_word[15:0]};
      F3_BU:   ld_data = {24'd0, sh_word[7:0]};
      F3_HU:   ld_data = {16'd0, sh_word[15:0]};
      default: ld_data = rd_word;
    endcase
  end

  logic [3:0]      wmask;
  logic [3:0][7:0] wlanes;
  logic            mem_we;

  // Store data is replicated across lanes so the mask alone selects the target bytes.
  always_comb begin
    wmask  = 4'b1111;
    wlanes = cur.wdata;
    case (cur.funct3)
      F3_BYTE: begin wmask = 4'b0001 << lane;                wlanes = {4{cur.wdata[7:0]}};  end
      F3_HALF: begin wmask = lane[1] ? 4'b1100 : 4'b0011;   wlanes = {2{cur.wdata[15:0]}}; end
      default: ;
    endcase
  end

  assign mem_we = access && cur.we && !err && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (wmask[i]) mem[idx][i] <= wlanes[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      req_q <= req_nxt;
      if (access) begin
        rsp_err   <= err;
        rsp_rdata <= (err || cur.we) ? 32'd0 : ld_data;
      end
    end
  end

  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (1 and 0 wait states) checked against a
// byte-array memory model with directed spec scenarios plus random traffic.
module tb_dmem_responder;
  localparam int D = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_funct3[2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  dmem_responder #(.DEPTH_WORDS(D), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  dmem_responder #(.DEPTH_WORDS(D), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  int checks = 0;
  int passes = 0;
  int tmo = 0;
  logic [7:0] mm [2][4*D];

  // Reference: size/sign from funct3, legality, alignment, range, then byte-array access.
  task automatic model(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int sz, ia;
    bit sx, ok;
    sz = 4; sx = 0; ok = 1;
    case (f3)
      3'd0: begin sz = 1; sx = 1; end
      3'd1: begin sz = 2; sx = 1; end
      3'd2: sz = 4;
      3'd4: begin sz = 1; ok = !we; end
      3'd5: begin sz = 2; ok = !we; end
      default: ok = 0;
    endcase
    er = !ok || ((a / 4) >= 32'(D)) || ((a % 32'(sz)) != 0);
    rd = '0;
    if (!er) begin
      ia = int'(a);
      if (we) begin
        for (int i = 0; i < sz; i++) mm[d][ia+i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++) rd[8*i +: 8] = mm[d][ia+i];
        if (sx && sz < 4 && rd[8*sz-1]) for (int i = 8*sz; i < 32; i++) rd[i] = 1'b1;
      end
    end
  endtask

  task automatic xact(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
    int n;
    rd = '0; er = 1'b0; lat = -1;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3; req_addr[d] = a; req_wdata[d] = wd;
    n = 0;
    while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
    if (!req_ready[d]) begin tmo++; req_valid[d] = 1'b0; return; end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    n = 1;
    while (!rsp_valid[d] && n < 50) begin @(posedge clk); #1; n++; end
    if (!rsp_valid[d]) begin tmo++; return; end
    lat = n; rd = rsp_rdata[d]; er = rsp_err[d];
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (rsp_valid[d] !== 1'b0) $display("FAIL rst_rsp_valid[%0d]: got %b want 0", d, rsp_valid[d]); else passes++;
      checks++; if (req_ready[d] !== 1'b0) $display("FAIL rst_req_ready[%0d]: got %b want 0", d, req_ready[d]); else passes++;
      checks++; if (rsp_rdata[d] !== 32'd0) $display("FAIL rst_rdata[%0d]: got %h want 0", d, rsp_rdata[d]); else passes++;
      checks++; if (rsp_err[d] !== 1'b0) $display("FAIL rst_err[%0d]: got %b want 0", d, rsp_err[d]); else passes++;
    end
    @(negedge clk); rst = 1'b0; #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (req_ready[d] !== 1'b1) $display("FAIL idle_req_ready[%0d]: got %b want 1", d, req_ready[d]); else passes++;
    end
  endtask

  task automatic fill();
    logic [31:0] rd, ed, w;
    logic er, ee;
    int lat;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < D; i++) begin
        w = $urandom;
        model(d, 1'b1, 3'd2, 32'(4*i), w, ed, ee);
        xact(d, 1'b1, 3'd2, 32'(4*i), w, rd, er, lat);
      end
  endtask

  task automatic test_word();
    logic [31:0] rd, ed; logic er, ee; int lat;
    model(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, ed, ee);
    xact(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checks++; if (lat !== 2) $display("FAIL sw_latency: got %0d want 2", lat); else passes++;
    checks++; if (er !== 1'b0 || rd !== 32'd0) $display("FAIL sw_rsp: got err=%b rdata=%h want err=0 rdata=0", er, rd); else passes++;
    xact(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) $display("FAIL lw_10: got %h err=%b want deadbeef", rd, er); else passes++;
    checks++; if (lat !== 2) $display("FAIL lw_latency: got %0d want 2", lat); else passes++;
  endtask

  task automatic test_byte();
    logic [31:0] rd, ed; logic er, ee; int lat;
    model(0, 1'b1, 3'd0, 32'h11, 32'h12345680, ed, ee);
    xact(0, 1'b1, 3'd0, 32'h11, 32'h12345680, rd, er, lat);
    xact(0, 1'b0, 3'd0, 32'h11, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFF80) $display("FAIL lb_11: got %h want ffffff80", rd); else passes++;
    xact(0, 1'b0, 3'd4, 32'h11, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00000080) $display("FAIL lbu_11: got %h want 00000080", rd); else passes++;
    xact(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEAD80EF) $display("FAIL lw_after_sb: got %h want dead80ef", rd); else passes++;
  endtask

  task automatic test_half();
    logic [31:0] rd, ed; logic er, ee; int lat;
    model(0, 1'b1, 3'd1, 32'h22, 32'hABCD1234, ed, ee);
    xact(0, 1'b1, 3'd1, 32'h22, 32'hABCD1234, rd, er, lat);
    xact(0, 1'b0, 3'd1, 32'h22, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00001234) $display("FAIL lh_1234: got %h want 00001234", rd); else passes++;
    model(0, 1'b1, 3'd1, 32'h22, 32'h0000F00D, ed, ee);
    xact(0, 1'b1, 3'd1, 32'h22, 32'h0000F00D, rd, er, lat);
    xact(0, 1'b0, 3'd1, 32'h22, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFF00D) $display("FAIL lh_f00d: got %h want fffff00d", rd); else passes++;
    xact(0, 1'b0, 3'd5, 32'h22, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000F00D) $display("FAIL lhu_f00d: got %h want 0000f00d", rd); else passes++;
  endtask

  task automatic test_errors();
    logic        we [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0]  f3 [6] = '{3'd2, 3'd1, 3'd3, 3'd2, 3'd4, 3'd1};
    logic [31:0] ad [6] = '{32'h13, 32'h21, 32'h10, 32'(4*D), 32'h10, 32'h11};
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 6; i++) begin
      xact(0, we[i], f3[i], ad[i], 32'h5A5A5A5A, rd, er, lat);
      checks++; if (er !== 1'b1 || rd !== 32'd0) $display("FAIL err_case%0d: got err=%b rdata=%h want err=1 rdata=0", i, er, rd); else passes++;
    end
    xact(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEAD80EF) $display("FAIL err_no_write: got %h want dead80ef", rd); else passes++;
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, ed, held; logic er, ee; int n;
    model(0, 1'b0, 3'd2, 32'h40, 32'h0, ed, ee);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_funct3[0] = 3'd2; req_addr[0] = 32'h10;
    checks++; if (req_ready[0] !== 1'b1) $display("FAIL bp_ready_idle: got %b want 1", req_ready[0]); else passes++;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (!rsp_valid[0] && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (rsp_valid[0] !== 1'b1) $display("FAIL bp_rsp_timeout: got %b want 1", rsp_valid[0]); else passes++;
    held = rsp_rdata[0];
    checks++; if (held !== 32'hDEAD80EF) $display("FAIL bp_rdata: got %h want dead80ef", held); else passes++;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'd2; req_addr[0] = 32'h40; req_wdata[0] = 32'h11111111;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid[0] !== 1'b1) $display("FAIL bp_valid_c%0d: got %b want 1", c, rsp_valid[0]); else passes++;
      checks++; if (req_ready[0] !== 1'b0) $display("FAIL bp_req_ready_c%0d: got %b want 0", c, req_ready[0]); else passes++;
      checks++; if (rsp_rdata[0] !== held) $display("FAIL bp_stable_c%0d: got %h want %h", c, rsp_rdata[0], held); else passes++;
    end
    req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    checks++; if (rsp_valid[0] !== 1'b0) $display("FAIL bp_release: got %b want 0", rsp_valid[0]); else passes++;
    xact(0, 1'b0, 3'd2, 32'h40, 32'h0, rd, er, n);
    checks++; if (rd !== ed) $display("FAIL bp_no_store: got %h want %h", rd, ed); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, ed; logic er, ee; int lat; bit seen;
    model(0, 1'b0, 3'd2, 32'h30, 32'h0, ed, ee);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'd2; req_addr[0] = 32'h30; req_wdata[0] = 32'h55;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst = 1'b1; #1;
    checks++; if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0) $display("FAIL midrst_ctrl: got valid=%b ready=%b want 0 0", rsp_valid[0], req_ready[0]); else passes++;
    checks++; if (rsp_rdata[0] !== 32'd0 || rsp_err[0] !== 1'b0) $display("FAIL midrst_data: got %h err=%b want 0 0", rsp_rdata[0], rsp_err[0]); else passes++;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (4) begin @(posedge clk); #1; if (rsp_valid[0]) seen = 1; end
    checks++; if (seen !== 1'b0) $display("FAIL midrst_no_rsp: got %b want 0", seen); else passes++;
    xact(0, 1'b0, 3'd2, 32'h30, 32'h0, rd, er, lat);
    checks++; if (rd !== ed) $display("FAIL midrst_no_write: got %h want %h", rd, ed); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, ed, a, w; logic er, ee; int lat;
    for (int i = 0; i < 6; i++) begin
      a = 32'(4 * $urandom_range(0, D-1)); w = $urandom;
      model(1, 1'b1, 3'd2, a, w, ed, ee);
      xact(1, 1'b1, 3'd2, a, w, rd, er, lat);
      checks++; if (lat !== 1) $display("FAIL b2b_sw_lat%0d: got %0d want 1", i, lat); else passes++;
      model(1, 1'b0, 3'd2, a, 32'h0, ed, ee);
      xact(1, 1'b0, 3'd2, a, 32'h0, rd, er, lat);
      checks++; if (lat !== 1 || rd !== ed) $display("FAIL b2b_lw%0d: got lat=%0d rdata=%h want lat=1 rdata=%h", i, lat, rd, ed); else passes++;
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, ed, a, w; logic er, ee, we; logic [2:0] f3; int lat, d, r;
    for (int i = 0; i < 300; i++) begin
      d = i % 2;
      r = $urandom_range(0, 19);
      a = (r < 17) ? 32'($urandom_range(0, 4*D-1)) : (r < 19) ? 32'(4*D + $urandom_range(0, 15)) : $urandom;
      we = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7)); w = $urandom;
      model(d, we, f3, a, w, ed, ee);
      xact(d, we, f3, a, w, rd, er, lat);
      checks++;
      if (rd !== ed || er !== ee || lat !== 2 - d)
        $display("FAIL rand%0d: dut%0d we=%b f3=%0d a=%h got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                 i, d, we, f3, a, rd, er, lat, ed, ee, 2 - d);
      else passes++;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = '0;
      req_addr[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b0;
    end
    test_reset();
    fill();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    checks++; if (tmo !== 0) $display("FAIL handshake_timeouts: got %0d want 0", tmo); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
